// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and elaboration helpers for the iterative magnitude comparator.
// Both the FSM encoding and the slice-index sizing live here so sub-blocks agree.
package seq_magnitude_comparator_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_result_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIGIT = 4;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int calc_idx_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  localparam int DEFAULT_IDX_W =
    calc_idx_width(calc_ndig(DEFAULT_WIDTH, DEFAULT_DIGIT));

endpackage

// File: rtl/seq_magnitude_comparator_digit_comparator.sv
// Combinational compare of one DIGIT-bit slice. Inverting the top bit of both
// slices turns an unsigned compare into a two's-complement compare.
module digit_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_invert_msb,
  output logic             o_eq,
  output logic             o_gt,
  output logic             o_lt
);

  logic [DIGIT-1:0] w_a;
  logic [DIGIT-1:0] w_b;

  always_comb begin
    // NOTE: every signal assigned here gets a full default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_a = i_a;
    w_b = i_b;
    w_a[DIGIT-1] = i_a[DIGIT-1] ^ i_invert_msb;
    w_b[DIGIT-1] = i_b[DIGIT-1] ^ i_invert_msb;
  end

  assign o_eq = (w_a == w_b);
  assign o_gt = (w_a >  w_b);
  assign o_lt = (w_a <  w_b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Iterative WIDTH-bit magnitude comparator: one DIGIT-bit slice per clock,
// MSB slice first, stopping on the first slice that differs.
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int KW   = calc_idx_width(NDIG);
  localparam logic [KW-1:0] LAST_K = KW'(NDIG - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("seq_magnitude_comparator: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [KW-1:0]    r_k;
  logic             r_done;
  cmp_result_t      r_result;

  logic [DIGIT-1:0] w_a_slice;
  logic [DIGIT-1:0] w_b_slice;
  logic             w_invert_msb;
  logic             w_slice_eq;
  logic             w_slice_gt;
  logic             w_slice_lt;
  logic             w_accept;
  logic             w_finish;

  // Slice mux: index 0 selects the most significant slice.
  if (NDIG == 1) begin : g_single
    assign w_a_slice = r_a;
    assign w_b_slice = r_b;
  end else begin : g_multi
    logic [DIGIT-1:0] w_a_digits [NDIG];
    logic [DIGIT-1:0] w_b_digits [NDIG];
    for (genvar i = 0; i < NDIG; i++) begin : g_split
      assign w_a_digits[i] = r_a[(NDIG-1-i)*DIGIT +: DIGIT];
      assign w_b_digits[i] = r_b[(NDIG-1-i)*DIGIT +: DIGIT];
    end
    assign w_a_slice = w_a_digits[r_k];
    assign w_b_slice = w_b_digits[r_k];
  end

  // Only the sign-carrying slice is biased in two's-complement mode.
  assign w_invert_msb = r_signed && (r_k == '0);

  digit_comparator #(
    .DIGIT (DIGIT)
  ) u_digit_cmp (
    .i_a          (w_a_slice),
    .i_b          (w_b_slice),
    .i_invert_msb (w_invert_msb),
    .o_eq         (w_slice_eq),
    .o_gt         (w_slice_gt),
    .o_lt         (w_slice_lt)
  );

  assign w_accept = (r_state == IDLE) && start;
  assign w_finish = (r_state == COMPARE) && (!w_slice_eq || (r_k == LAST_K));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start)    w_next_state = COMPARE;
      COMPARE: if (w_finish) w_next_state = IDLE;
      default:               w_next_state = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (r_state == COMPARE);
    done = r_done;
    eq   = r_result.eq;
    gt   = r_result.gt;
    lt   = r_result.lt;
  end

  // Operand capture and slice walk; inputs are ignored once a compare runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset too; they are plain flops, not a
      // RAM, so the reset is free and keeps post-reset state deterministic.
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_k      <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_signed <= signed_mode;
      r_k      <= '0;
    end else if ((r_state == COMPARE) && !w_finish) begin
      r_k      <= r_k + KW'(1);
    end
  end

  // Result registers: updated only when a compare completes, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_result <= '{eq: w_slice_eq, gt: w_slice_gt, lt: w_slice_lt};
      end
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench: directed scenarios plus a randomized sweep against a
// whole-word arithmetic model, and a single-slice WIDTH=DIGIT=8 instance.
module tb_seq_magnitude_comparator;

  localparam int W    = 16;
  localparam int D    = 4;
  localparam int NDIG = W / D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          signed_mode = 1'b0;
  logic          busy, done, eq, gt, lt;

  logic          start8 = 1'b0;
  logic [7:0]    a8 = '0;
  logic [7:0]    b8 = '0;
  logic          sm8 = 1'b0;
  logic          busy8, done8, eq8, gt8, lt8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .busy(busy), .done(done),
    .eq(eq), .gt(gt), .lt(lt)
  );

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .signed_mode(sm8), .busy(busy8), .done(done8),
    .eq(eq8), .gt(gt8), .lt(lt8)
  );

  // Reference: whole-word arithmetic compare, result packed as {eq,gt,lt}.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic sm);
    int xi, yi;
    if (sm) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
    end else begin
      xi = int'(x);
      yi = int'(y);
    end
    return {xi == yi, xi > yi, xi < yi};
  endfunction

  // Reference latency: 1 + index of the first differing digit from the top.
  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int k = 0; k < NDIG; k++) begin
      if (((x >> (W - D*(k+1))) & 16'hF) != ((y >> (W - D*(k+1))) & 16'hF)) return k + 1;
    end
    return NDIG;
  endfunction

  // Issue one compare on the 16-bit DUT; returns latency and {eq,gt,lt} at done.
  task automatic run16(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic sm,
                       output int lat, output logic [2:0] res, output logic timeout);
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb_v; signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    lat = 0; res = '0; timeout = 1'b1;
    for (int n = 1; n <= NDIG + 4; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n; res = {eq, gt, lt}; timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, eq, gt, lt} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {busy, done, eq, gt, lt});
    end
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy=%b expected 0", busy);
    end
    start = 1'b0;
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, eq, gt, lt, busy8, done8, eq8, gt8, lt8} !== 10'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 0000000000",
               {busy, done, eq, gt, lt, busy8, done8, eq8, gt8, lt8});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{16'h00FF, 16'hFF00, 16'hFF00, 16'h8000};
    logic [W-1:0] tv [4] = '{16'h00FF, 16'h0000, 16'h0000, 16'h8001};
    logic         ts [4] = '{1'b0,     1'b0,     1'b1,     1'b1};
    logic [2:0]   te [4] = '{3'b100,   3'b010,   3'b001,   3'b001};
    int           tl [4] = '{4,        1,        1,        4};
    int lat; logic [2:0] res; logic to;
    for (int i = 0; i < 4; i++) begin
      run16(ta[i], tv[i], ts[i], lat, res, to);
      checks++;
      if (to || res !== te[i] || lat != tl[i]) begin
        errors++;
        $display("FAIL directed_%0d: timeout=%b res=%b lat=%0d expected res=%b lat=%0d",
                 i, to, res, lat, te[i], tl[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {eq, gt, lt} !== te[i]) begin
        errors++;
        $display("FAIL directed_hold_%0d: done=%b busy=%b res=%b expected done=0 busy=0 res=%b",
                 i, done, busy, {eq, gt, lt}, te[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1234; b = 16'h1235; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL busy_cycle2: busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    start = 1'b1; a = 16'hFFFF; b = 16'h0000; signed_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL busy_cycle3: done=%b expected 0", done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || {eq, gt, lt} !== 3'b001) begin
      errors++;
      $display("FAIL busy_ignore_result: done=%b res=%b expected done=1 res=001", done, {eq, gt, lt});
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_ghost: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [2:0] res; logic to; logic seen;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h0010; b = 16'h0001; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || lt !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: busy=%b lt=%b expected 1 1", busy, lt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, eq, gt, lt} !== 5'b0) begin
      errors++;
      $display("FAIL abort_async: got %b expected 00000", {busy, done, eq, gt, lt});
    end
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    #3 rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done_seen=%b busy=%b expected 0 0", seen, busy);
    end
    run16(16'h0010, 16'h0001, 1'b0, lat, res, to);
    checks++;
    if (to || res !== 3'b010 || lat != 3) begin
      errors++;
      $display("FAIL abort_recover: timeout=%b res=%b lat=%0d expected res=010 lat=3", to, res, lat);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    start = 1'b1; a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_busy: busy=%b expected 1", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {eq, gt, lt} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_first: done=%b busy=%b res=%b expected 1 0 010", done, busy, {eq, gt, lt});
    end
    start = 1'b1; signed_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || {eq, gt, lt} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_second: done=%b res=%b expected 1 001", done, {eq, gt, lt});
    end
  endtask

  task automatic test_single_slice();
    logic [7:0] ta [3] = '{8'h80, 8'h80, 8'h5A};
    logic [7:0] tv [3] = '{8'h7F, 8'h7F, 8'h5A};
    logic       ts [3] = '{1'b1,  1'b0,  1'b1};
    logic [2:0] te [3] = '{3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start8 = 1'b1; a8 = ta[i]; b8 = tv[i]; sm8 = ts[i];
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (done8 !== 1'b1 || {eq8, gt8, lt8} !== te[i]) begin
        errors++;
        $display("FAIL single_slice_%0d: done=%b res=%b expected done=1 res=%b",
                 i, done8, {eq8, gt8, lt8}, te[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [2:0] res; logic to;
    logic [W-1:0] x, y, mask;
    logic sm;
    for (int i = 0; i < 1000; i++) begin
      x  = W'($urandom);
      y  = W'($urandom);
      sm = 1'($urandom_range(0, 1));
      if (i % 2 == 1) begin
        mask = W'(16'hFFFF << (D * $urandom_range(0, NDIG)));
        y = (x & mask) | (y & ~mask);
      end
      run16(x, y, sm, lat, res, to);
      checks++;
      if (to || res !== ref_cmp(x, y, sm) || lat != ref_lat(x, y)) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h sm=%b timeout=%b res=%b lat=%0d expected res=%b lat=%0d",
                 i, x, y, sm, to, res, lat, ref_cmp(x, y, sm), ref_lat(x, y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_single_slice();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
